// File: rtl/ssd_mux_driver.sv
// Time-multiplexed seven-segment driver: scans one digit per slot with PWM dimming,
// optional leading-zero blanking, and a shadow/active register pair committed only at frame boundaries.
module ssd_mux_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 17,
    parameter int BRIGHT_W   = 4,
    parameter int LZ_BLANK   = 0
) (
    input  logic                    ssd_mux_driver_port_clk,
    input  logic                    ssd_mux_driver_port_rst_n,
    input  logic [4*NUM_DIGITS-1:0] ssd_mux_driver_port_data_in,
    input  logic [NUM_DIGITS-1:0]   ssd_mux_driver_port_dp_in,
    input  logic [NUM_DIGITS-1:0]   ssd_mux_driver_port_blank_in,
    input  logic                    ssd_mux_driver_port_load,
    input  logic [BRIGHT_W-1:0]     ssd_mux_driver_port_bright,
    output logic [NUM_DIGITS-1:0]   ssd_mux_driver_port_an,
    output logic [6:0]              ssd_mux_driver_port_cc,
    output logic                    ssd_mux_driver_port_dp_out,
    output logic                    ssd_mux_driver_port_upd_done,
    output logic                    ssd_mux_driver_port_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic                    act_valid_q, act_valid_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              cc_q, cc_d;
    logic                    dp_out_q, dp_out_d;
    logic                    upd_done_q, upd_done_d;
    logic                    frame_q, frame_d;

    logic                    slot_end;
    logic                    boundary;
    logic [3:0]              nibble;
    logic                    upper_nonzero;
    logic                    lz_dark;
    logic [BRIGHT_W-1:0]     phase;
    logic                    lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A load on the boundary cycle bypasses the shadow so it is not delayed a whole frame.
    always_comb begin
        slot_end    = &cnt_q;
        boundary    = slot_end && (idx_q == LAST_IDX);
        cnt_d       = cnt_q + DIV_LOG2'(1);
        idx_d       = idx_q;
        shd_data_d  = shd_data_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        pending_d   = pending_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_valid_d = act_valid_q;
        upd_done_d  = 1'b0;
        frame_d     = boundary;

        if (slot_end) begin
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end

        if (boundary) begin
            if (ssd_mux_driver_port_load) begin
                act_data_d  = ssd_mux_driver_port_data_in;
                act_dp_d    = ssd_mux_driver_port_dp_in;
                act_blank_d = ssd_mux_driver_port_blank_in;
                act_valid_d = 1'b1;
                pending_d   = 1'b0;
                upd_done_d  = 1'b1;
            end else if (pending_q) begin
                act_data_d  = shd_data_q;
                act_dp_d    = shd_dp_q;
                act_blank_d = shd_blank_q;
                act_valid_d = 1'b1;
                pending_d   = 1'b0;
                upd_done_d  = 1'b1;
            end
        end else if (ssd_mux_driver_port_load) begin
            shd_data_d  = ssd_mux_driver_port_data_in;
            shd_dp_d    = ssd_mux_driver_port_dp_in;
            shd_blank_d = ssd_mux_driver_port_blank_in;
            pending_d   = 1'b1;
        end
    end

    // Nothing is lit until the first commit, so the power-up zeros never flash on the display.
    always_comb begin
        nibble        = act_data_q[4*int'(idx_q) +: 4];
        upper_nonzero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (act_data_q[4*j +: 4] != 4'h0)) begin
                upper_nonzero = 1'b1;
            end
        end
        lz_dark  = (LZ_BLANK != 0) && (idx_q != '0) && !upper_nonzero;
        phase    = cnt_q[DIV_LOG2-1 -: BRIGHT_W];
        lit      = act_valid_q && !act_blank_q[idx_q] && !lz_dark &&
                   (phase <= ssd_mux_driver_port_bright);
        an_d     = '1;
        cc_d     = 7'h7F;
        dp_out_d = 1'b1;
        if (lit) begin
            an_d     = ~(NUM_DIGITS'(1) << idx_q);
            cc_d     = seg_decode(nibble);
            dp_out_d = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge ssd_mux_driver_port_clk or negedge ssd_mux_driver_port_rst_n) begin
        if (!ssd_mux_driver_port_rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shd_data_q  <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '0;
            pending_q   <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            act_valid_q <= 1'b0;
            an_q        <= '1;
            cc_q        <= 7'h7F;
            dp_out_q    <= 1'b1;
            upd_done_q  <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shd_data_q  <= shd_data_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            pending_q   <= pending_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            act_valid_q <= act_valid_d;
            an_q        <= an_d;
            cc_q        <= cc_d;
            dp_out_q    <= dp_out_d;
            upd_done_q  <= upd_done_d;
            frame_q     <= frame_d;
        end
    end

    assign ssd_mux_driver_port_an       = an_q;
    assign ssd_mux_driver_port_cc       = cc_q;
    assign ssd_mux_driver_port_dp_out   = dp_out_q;
    assign ssd_mux_driver_port_upd_done = upd_done_q;
    assign ssd_mux_driver_port_frame    = frame_q;

endmodule
